operand_forward_stage: RTL and testbench



---
 rtl/operand_forward_stage_pkg.sv | 17 +
 rtl/operand_forward_stage_cdb_match.sv | 28 ++
 rtl/operand_forward_stage.sv | 103 ++++++++++
 tb/tb_operand_forward_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_forward_stage_pkg.sv
// Shared widths, the "no operand" tag value and the per-source operand record
// used by the operand forwarding stage and its CDB matcher.
package operand_forward_stage_pkg;

  localparam int XLEN_DEFAULT      = 32;
  localparam int TAG_WIDTH_DEFAULT = 6;

  // Tag 0 names x0 or an unused source slot; such an operand is always ready as zero.
  localparam int TAG_ZERO = 0;

  typedef struct packed {
    logic [TAG_WIDTH_DEFAULT-1:0] tag;
    logic [XLEN_DEFAULT-1:0]      data;
    logic                         valid;
  } src_operand_t;

endpackage

// File: rtl/operand_forward_stage_cdb_match.sv
// Looks one source tag up against every common data bus; the lowest-index
// valid bus carrying that tag supplies the data.
module cdb_match #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6,
  parameter int CDB_COUNT = 2
) (
  input  logic [TAG_WIDTH-1:0]           tag,
  input  logic [CDB_COUNT-1:0]           cdb_valid,
  input  logic [CDB_COUNT*TAG_WIDTH-1:0] cdb_tag,
  input  logic [CDB_COUNT*XLEN-1:0]      cdb_result,
  output logic                           hit,
  output logic [XLEN-1:0]                data
);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int c = CDB_COUNT - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        hit  = 1'b1;
        data = cdb_result[c*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/operand_forward_stage.sv
// Registered issue-to-reservation-station stage: resolves source operands from
// tag zero, the CDBs or the register file, and keeps waking them while stalled.
module operand_forward_stage
  import operand_forward_stage_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int TAG_WIDTH     = TAG_WIDTH_DEFAULT,
  parameter int SRC_COUNT     = 2,
  parameter int CDB_COUNT     = 2,
  parameter int PAYLOAD_WIDTH = 96
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]       in_payload,
  input  logic [SRC_COUNT*TAG_WIDTH-1:0] in_tag,
  input  logic [SRC_COUNT*XLEN-1:0]      rf_data,
  input  logic [SRC_COUNT-1:0]           rf_valid,
  input  logic [CDB_COUNT-1:0]           cdb_valid,
  input  logic [CDB_COUNT*TAG_WIDTH-1:0] cdb_tag,
  input  logic [CDB_COUNT*XLEN-1:0]      cdb_result,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PAYLOAD_WIDTH-1:0]       out_payload,
  output logic [SRC_COUNT*TAG_WIDTH-1:0] out_tag,
  output logic [SRC_COUNT*XLEN-1:0]      out_data,
  output logic [SRC_COUNT-1:0]           out_op_valid,
  output logic                           out_all_valid
);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; in_ready is !out_valid || out_ready so a draining entry is replaced
  // in the same cycle, and flush only suppresses the capture, not in_ready.
  logic                           capture;
  logic [SRC_COUNT*TAG_WIDTH-1:0] lookup_tag;
  logic [SRC_COUNT-1:0]           hit;
  logic [SRC_COUNT*XLEN-1:0]      hit_data;

  assign in_ready      = !out_valid || out_ready;
  assign capture       = in_valid && in_ready && !flush;
  assign out_all_valid = out_valid && (&out_op_valid);

  // One matcher per source, shared between capture (incoming tag) and hold
  // (held tag); the two never happen in the same cycle.
  for (genvar s = 0; s < SRC_COUNT; s++) begin : g_src
    assign lookup_tag[s*TAG_WIDTH +: TAG_WIDTH] =
      capture ? in_tag[s*TAG_WIDTH +: TAG_WIDTH] : out_tag[s*TAG_WIDTH +: TAG_WIDTH];

    cdb_match #(
      .XLEN      (XLEN),
      .TAG_WIDTH (TAG_WIDTH),
      .CDB_COUNT (CDB_COUNT)
    ) u_match (
      .tag        (lookup_tag[s*TAG_WIDTH +: TAG_WIDTH]),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_result (cdb_result),
      .hit        (hit[s]),
      .data       (hit_data[s*XLEN +: XLEN])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_payload  <= '0;
      out_tag      <= '0;
      out_data     <= '0;
      out_op_valid <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_payload <= in_payload;
      out_tag     <= in_tag;
      for (int s = 0; s < SRC_COUNT; s++) begin
        if (in_tag[s*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(TAG_ZERO)) begin
          out_data[s*XLEN +: XLEN] <= '0;
          out_op_valid[s]          <= 1'b1;
        end else if (hit[s]) begin
          out_data[s*XLEN +: XLEN] <= hit_data[s*XLEN +: XLEN];
          out_op_valid[s]          <= 1'b1;
        end else begin
          out_data[s*XLEN +: XLEN] <= rf_data[s*XLEN +: XLEN];
          out_op_valid[s]          <= rf_valid[s];
        end
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Stalled: only still-pending operands may be woken by a CDB result.
      for (int s = 0; s < SRC_COUNT; s++) begin
        if (!out_op_valid[s] && hit[s]) begin
          out_data[s*XLEN +: XLEN] <= hit_data[s*XLEN +: XLEN];
          out_op_valid[s]          <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_forward_stage.sv
// Bench for operand_forward_stage: vector table, random stream with a reference
// resolver, and hand-written stall, wakeup, flush and reset sequences.
module tb_operand_forward_stage;
  import operand_forward_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int TW    = 6;
  localparam int NSRC  = 2;
  localparam int NCDB  = 2;
  localparam int PW    = 96;
  localparam int EXP_W = PW + NSRC*TW + NSRC*XLEN + NSRC + 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [PW-1:0]        in_payload;
  logic [NSRC*TW-1:0]   in_tag;
  logic [NSRC*XLEN-1:0] rf_data;
  logic [NSRC-1:0]      rf_valid;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*TW-1:0]   cdb_tag;
  logic [NCDB*XLEN-1:0] cdb_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [PW-1:0]        out_payload;
  logic [NSRC*TW-1:0]   out_tag;
  logic [NSRC*XLEN-1:0] out_data;
  logic [NSRC-1:0]      out_op_valid;
  logic                 out_all_valid;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  operand_forward_stage #(
    .XLEN(XLEN), .TAG_WIDTH(TW), .SRC_COUNT(NSRC), .CDB_COUNT(NCDB), .PAYLOAD_WIDTH(PW)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_tag(in_tag),
    .rf_data(rf_data), .rf_valid(rf_valid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_tag(out_tag), .out_data(out_data), .out_op_valid(out_op_valid),
    .out_all_valid(out_all_valid)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_payload = '0;
    in_tag     = '0;
    rf_data    = '0;
    rf_valid   = '0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    cdb_result = '0;
  endtask

  task automatic push_exp(input logic [PW-1:0] p, input logic [NSRC*TW-1:0] t,
                          input logic [NSRC*XLEN-1:0] d, input logic [NSRC-1:0] v);
    exp_q.push_back({p, t, d, v, &v});
  endtask

  // Reference resolution of one source at capture time.
  function automatic src_operand_t model_src(input logic [TW-1:0] t, input logic [XLEN-1:0] rfd,
                                             input logic rfv);
    src_operand_t r;
    r.tag = t;
    if (t == '0) begin
      r.data = '0; r.valid = 1'b1;
    end else if (cdb_valid[0] && cdb_tag[TW-1:0] == t) begin
      r.data = cdb_result[XLEN-1:0]; r.valid = 1'b1;
    end else if (cdb_valid[1] && cdb_tag[2*TW-1:TW] == t) begin
      r.data = cdb_result[2*XLEN-1:XLEN]; r.valid = 1'b1;
    end else begin
      r.data = rfd; r.valid = rfv;
    end
    return r;
  endfunction

  // ---------------- scoreboard: compare every accepted output ----------------
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_output actual_payload=%0h required=no_output", out_payload);
      end else begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] a;
        e = exp_q.pop_front();
        a = {out_payload, out_tag, out_data, out_op_valid, out_all_valid};
        if (a !== e) begin
          errors++;
          $display("FAIL sb_entry actual=%0h expected=%0h", a, e);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [PW-1:0]   payload;
    logic [TW-1:0]   t0, t1;
    logic [XLEN-1:0] rf0, rf1;
    logic [1:0]      rfv;
    logic [1:0]      cv;
    logic [TW-1:0]   ct0, ct1;
    logic [XLEN-1:0] cr0, cr1;
    logic [XLEN-1:0] ed0, ed1;
    logic [1:0]      ev;
  } vec_t;

  vec_t vecs[8];

  initial begin
    src_operand_t m0, m1;
    vecs[0] = '{96'h100, 6'd5, 6'd7, 32'h1111, 32'h2222, 2'b11, 2'b01, 6'd9, 6'd0,
                32'hDEAD0009, 32'h0, 32'h1111, 32'h2222, 2'b11};
    vecs[1] = '{96'h101, 6'd5, 6'd7, 32'hAAAA, 32'hBBBB, 2'b00, 2'b11, 6'd5, 6'd5,
                32'h1, 32'h2, 32'h1, 32'hBBBB, 2'b01};
    vecs[2] = '{96'h102, 6'd5, 6'd7, 32'hCCCC, 32'hDDDD, 2'b00, 2'b00, 6'd5, 6'd7,
                32'h3, 32'h4, 32'hCCCC, 32'hDDDD, 2'b00};
    vecs[3] = '{96'h103, 6'd3, 6'd0, 32'h3333, 32'hFFFF, 2'b01, 2'b11, 6'd0, 6'd3,
                32'hABC, 32'hE3, 32'hE3, 32'h0, 2'b11};
    vecs[4] = '{96'h104, 6'd12, 6'd12, 32'h0, 32'h0, 2'b00, 2'b10, 6'd12, 6'd12,
                32'h44, 32'h55, 32'h55, 32'h55, 2'b11};
    vecs[5] = '{96'h105, 6'd8, 6'd4, 32'h8888, 32'h4444, 2'b00, 2'b11, 6'd4, 6'd8,
                32'h40, 32'h80, 32'h80, 32'h40, 2'b11};
    vecs[6] = '{96'h106, 6'd2, 6'd63, 32'h2222, 32'h6363, 2'b10, 2'b01, 6'd62, 6'd0,
                32'h62, 32'h0, 32'h2222, 32'h6363, 2'b10};
    vecs[7] = '{96'h107, 6'd0, 6'd0, 32'hFFFFFFFF, 32'h1, 2'b00, 2'b11, 6'd0, 6'd0,
                32'h9, 32'h9, 32'h0, 32'h0, 2'b11};

    // ---- reset ----
    idle_inputs();
    out_ready = 1'b0;
    reset     = 1'b1;
    step();
    step();
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_payload", 256'(out_payload), 256'(0));
    chk("reset_tag", 256'(out_tag), 256'(0));
    chk("reset_data", 256'(out_data), 256'(0));
    chk("reset_op_valid", 256'(out_op_valid), 256'(0));
    chk("reset_all_valid", 256'(out_all_valid), 256'(0));
    reset = 1'b0;
    step();
    chk("reset_in_ready", 256'(in_ready), 256'(1));

    // ---- table: back-to-back with out_ready=1 ----
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_payload = vecs[i].payload;
      in_tag     = {vecs[i].t1, vecs[i].t0};
      rf_data    = {vecs[i].rf1, vecs[i].rf0};
      rf_valid   = vecs[i].rfv;
      cdb_valid  = vecs[i].cv;
      cdb_tag    = {vecs[i].ct1, vecs[i].ct0};
      cdb_result = {vecs[i].cr1, vecs[i].cr0};
      push_exp(vecs[i].payload, in_tag, {vecs[i].ed1, vecs[i].ed0}, vecs[i].ev);
      #1;
      chk("stream_in_ready", 256'(in_ready), 256'(1));
      step();
    end
    idle_inputs();
    step();
    chk("drain_out_valid", 256'(out_valid), 256'(0));

    // ---- random stream against the reference resolver ----
    for (int i = 0; i < 40; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_payload = {64'h0, 32'($urandom)};
      in_tag     = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      rf_data    = {32'($urandom), 32'($urandom)};
      rf_valid   = 2'($urandom_range(0, 3));
      cdb_valid  = 2'($urandom_range(0, 3));
      cdb_tag    = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      cdb_result = {32'($urandom), 32'($urandom)};
      if (in_valid) begin
        m0 = model_src(in_tag[TW-1:0], rf_data[XLEN-1:0], rf_valid[0]);
        m1 = model_src(in_tag[2*TW-1:TW], rf_data[2*XLEN-1:XLEN], rf_valid[1]);
        push_exp(in_payload, in_tag, {m1.data, m0.data}, {m1.valid, m0.valid});
      end
      step();
    end
    idle_inputs();
    step();

    // ---- stall with late CDB wakeup; valid operand must not be overwritten ----
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 96'h200;
    in_tag     = {6'd7, 6'd5};
    rf_data    = {32'h77, 32'h0};
    rf_valid   = 2'b10;
    push_exp(96'h200, {6'd7, 6'd5}, {32'h77, 32'hDEADBEEF}, 2'b11);
    step();
    in_payload = 96'h2FF;
    in_tag     = {6'd1, 6'd1};
    cdb_valid  = 2'b00;
    cdb_tag    = {6'd0, 6'd5};
    cdb_result = {32'h0, 32'h5555};
    #1;
    chk("stall_in_ready", 256'(in_ready), 256'(0));
    chk("stall_out_valid", 256'(out_valid), 256'(1));
    chk("stall_op_valid", 256'(out_op_valid), 256'(2'b10));
    chk("stall_all_valid", 256'(out_all_valid), 256'(0));
    step();
    chk("stall_invalid_cdb_ignored", 256'(out_op_valid), 256'(2'b10));
    chk("stall_payload_held", 256'(out_payload), 256'(96'h200));
    step();
    cdb_valid  = 2'b11;
    cdb_tag    = {6'd5, 6'd7};
    cdb_result = {32'hDEADBEEF, 32'h99};
    step();
    chk("wake_data", 256'(out_data), 256'({32'h77, 32'hDEADBEEF}));
    chk("wake_op_valid", 256'(out_op_valid), 256'(2'b11));
    chk("wake_all_valid", 256'(out_all_valid), 256'(1));
    chk("wake_tag_held", 256'(out_tag), 256'({6'd7, 6'd5}));
    idle_inputs();
    out_ready = 1'b1;
    step();
    chk("wake_dequeued", 256'(out_valid), 256'(0));

    // ---- CDB coincident with dequeue: only the new entry sees it ----
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 96'h300;
    in_tag     = {6'd0, 6'd9};
    rf_data    = {32'h0, 32'h1234};
    rf_valid   = 2'b00;
    push_exp(96'h300, {6'd0, 6'd9}, {32'h0, 32'h1234}, 2'b10);
    step();
    out_ready  = 1'b1;
    in_payload = 96'h301;
    cdb_valid  = 2'b01;
    cdb_tag    = {6'd0, 6'd9};
    cdb_result = {32'h0, 32'hCAFE};
    push_exp(96'h301, {6'd0, 6'd9}, {32'h0, 32'hCAFE}, 2'b11);
    step();
    in_valid  = 1'b0;
    step();
    cdb_valid = 2'b01;
    step();
    chk("dequeue_cdb_no_capture", 256'(out_valid), 256'(0));
    idle_inputs();

    // ---- flush while holding, and flush of an idle-cycle issue ----
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 96'h400;
    in_tag     = {6'd7, 6'd5};
    rf_valid   = 2'b11;
    step();
    in_payload = 96'h401;
    flush      = 1'b1;
    step();
    chk("flush_hold_out_valid", 256'(out_valid), 256'(0));
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 256'(in_ready), 256'(1));
    step();
    chk("flush_drop_issue", 256'(out_valid), 256'(0));
    idle_inputs();

    // ---- reset in the middle of a stall ----
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_payload = 96'h500;
    in_tag     = {6'd3, 6'd4};
    rf_data    = {32'h33, 32'h44};
    rf_valid   = 2'b11;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_reset_hold", 256'(out_valid), 256'(1));
    reset = 1'b1;
    step();
    chk("midreset_out_valid", 256'(out_valid), 256'(0));
    chk("midreset_outputs", 256'({out_payload, out_tag, out_data, out_op_valid, out_all_valid}),
        256'(0));
    reset = 1'b0;
    step();

    chk("sb_all_consumed", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
